// File: rtl/fp_hazard_stall_ctrl_if.sv
// rtl/fp_hazard_stall_ctrl_if.sv - issue/stall/writeback bundle between decode and the FP hazard controller
// fwd_sel1/fwd_sel2 exist only when FP_HAZ_FWD_EN is defined.
interface fp_hazard_stall_ctrl_if #(
    parameter int REG_AW = 3
);
    logic              issue_valid;
    logic              is_mul;
    logic              src1_used;
    logic [REG_AW-1:0] src1_addr;
    logic              src2_used;
    logic [REG_AW-1:0] src2_addr;
    logic              dst_wr_en;
    logic [REG_AW-1:0] dst_addr;
    logic              issue_accept;
    logic              haz_stall;
    logic              mul_stall;
    logic              stall;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
`ifdef FP_HAZ_FWD_EN
    logic              fwd_sel1;
    logic              fwd_sel2;

    modport master (
        output issue_valid, is_mul, src1_used, src1_addr, src2_used, src2_addr,
               dst_wr_en, dst_addr,
        input  issue_accept, haz_stall, mul_stall, stall, wb_valid, wb_addr,
               fwd_sel1, fwd_sel2
    );

    modport slave (
        input  issue_valid, is_mul, src1_used, src1_addr, src2_used, src2_addr,
               dst_wr_en, dst_addr,
        output issue_accept, haz_stall, mul_stall, stall, wb_valid, wb_addr,
               fwd_sel1, fwd_sel2
    );
`else
    modport master (
        output issue_valid, is_mul, src1_used, src1_addr, src2_used, src2_addr,
               dst_wr_en, dst_addr,
        input  issue_accept, haz_stall, mul_stall, stall, wb_valid, wb_addr
    );

    modport slave (
        input  issue_valid, is_mul, src1_used, src1_addr, src2_used, src2_addr,
               dst_wr_en, dst_addr,
        output issue_accept, haz_stall, mul_stall, stall, wb_valid, wb_addr
    );
`endif
endinterface

// File: rtl/fp_hazard_stall_ctrl.sv
// rtl/fp_hazard_stall_ctrl.sv - FP issue scheduler: RAW scoreboard, multiplier stall, global stall
// Optional writeback-entry forwarding is enabled by defining FP_HAZ_FWD_EN.
module fp_hazard_stall_ctrl #(
    parameter int REG_AW     = 3,
    parameter int PIPE_DEPTH = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fp_hazard_stall_ctrl_if.slave bus
);
    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_CYCLES >= 2) ? (MUL_CYCLES - 2) : 0);
    localparam int LAST = PIPE_DEPTH - 1;
`ifdef FP_HAZ_FWD_EN
    // The writeback entry is forwarded, so it never needs to stall decode.
    localparam int CMP_N = PIPE_DEPTH - 1;
`else
    localparam int CMP_N = PIPE_DEPTH;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mul_state_t;

    mul_state_t        r_state;
    mul_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [PIPE_DEPTH-1:0] r_sb_valid;
    logic [REG_AW-1:0]     r_sb_addr [PIPE_DEPTH];

    logic w_mul_stall;
    logic w_haz1;
    logic w_haz2;
    logic w_haz_stall;
    logic w_stall;
    logic w_accept;

    assign w_mul_stall = (r_state == ST_BUSY);

    always_comb begin
        w_haz1 = 1'b0;
        w_haz2 = 1'b0;
        for (int i = 0; i < CMP_N; i++) begin
            if (r_sb_valid[i] && bus.src1_used && (r_sb_addr[i] == bus.src1_addr)) begin
                w_haz1 = 1'b1;
            end
            if (r_sb_valid[i] && bus.src2_used && (r_sb_addr[i] == bus.src2_addr)) begin
                w_haz2 = 1'b1;
            end
        end
    end

    assign w_haz_stall = bus.issue_valid & ~w_mul_stall & (w_haz1 | w_haz2);
    assign w_stall     = w_haz_stall | w_mul_stall;
    // Reset gates accept combinationally so nothing leaks out while reset is held.
    assign w_accept    = bus.issue_valid & ~w_stall & ~i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sb_valid <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_sb_addr[i] <= '0;
            end
        end else if (!w_mul_stall) begin
            r_sb_valid   <= {r_sb_valid[PIPE_DEPTH-2:0], w_accept & bus.dst_wr_en};
            r_sb_addr[0] <= bus.dst_addr;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_sb_addr[i] <= r_sb_addr[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // BUSY lasts r_cnt+1 cycles, i.e. MUL_CYCLES-1 cycles after the accept.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && bus.is_mul && (MUL_CYCLES > 1)) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.issue_accept = w_accept;
    assign bus.haz_stall    = w_haz_stall;
    assign bus.mul_stall    = w_mul_stall;
    assign bus.stall        = w_stall;
    assign bus.wb_valid     = r_sb_valid[LAST];
    assign bus.wb_addr      = r_sb_addr[LAST];

`ifdef FP_HAZ_FWD_EN
    assign bus.fwd_sel1 = bus.src1_used & r_sb_valid[LAST] &
                          (r_sb_addr[LAST] == bus.src1_addr) & ~w_mul_stall;
    assign bus.fwd_sel2 = bus.src2_used & r_sb_valid[LAST] &
                          (r_sb_addr[LAST] == bus.src2_addr) & ~w_mul_stall;
`endif

endmodule

// File: tb/tb_fp_hazard_stall_ctrl.sv
// tb/tb_fp_hazard_stall_ctrl.sv - scoreboard bench for fp_hazard_stall_ctrl with an age-based reference model
module tb_fp_hazard_stall_ctrl;
    localparam int AW   = 3;
    localparam int D    = 4;
    localparam int MULC = 3;
`ifdef FP_HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;

    fp_hazard_stall_ctrl_if #(.REG_AW(AW)) bus ();

    fp_hazard_stall_ctrl #(
        .REG_AW    (AW),
        .PIPE_DEPTH(D),
        .MUL_CYCLES(MULC)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          age;
        logic [AW-1:0] addr;
    } pend_t;

    typedef struct {
        logic          acc;
        logic          haz;
        logic          mul;
        logic          stall;
        logic          wbv;
        logic [AW-1:0] wba;
        logic          f1;
        logic          f2;
    } exp_t;

    pend_t pend[$];
    exp_t  exp_q[$];
    int    mul_rem;
    int    n_total;
    int    n_pass;
    int    haz_cnt;
    int    mul_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        haz_cnt += int'(bus.haz_stall);
        mul_cnt += int'(bus.mul_stall);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue_accept", 32'(bus.issue_accept), 32'(e.acc));
            check("haz_stall",    32'(bus.haz_stall),    32'(e.haz));
            check("mul_stall",    32'(bus.mul_stall),    32'(e.mul));
            check("stall",        32'(bus.stall),        32'(e.stall));
            check("wb_valid",     32'(bus.wb_valid),     32'(e.wbv));
            if (e.wbv) check("wb_addr", 32'(bus.wb_addr), 32'(e.wba));
`ifdef FP_HAZ_FWD_EN
            check("fwd_sel1", 32'(bus.fwd_sel1), 32'(e.f1));
            check("fwd_sel2", 32'(bus.fwd_sel2), 32'(e.f2));
`endif
        end
    end

    // One issue cycle: drive decode, predict from in-flight write ages, then age the model.
    task automatic step(input logic iv, input logic im,
                        input logic s1u, input logic [AW-1:0] s1a,
                        input logic s2u, input logic [AW-1:0] s2a,
                        input logic dwe, input logic [AW-1:0] da,
                        output logic acc);
        exp_t e;
        logic hit;
        @(posedge clk);
        #1;
        bus.issue_valid = iv;
        bus.is_mul      = im;
        bus.src1_used   = s1u;
        bus.src1_addr   = s1a;
        bus.src2_used   = s2u;
        bus.src2_addr   = s2a;
        bus.dst_wr_en   = dwe;
        bus.dst_addr    = da;

        e.mul = (mul_rem > 0);
        e.wbv = 1'b0;
        e.wba = '0;
        e.f1  = 1'b0;
        e.f2  = 1'b0;
        hit   = 1'b0;
        foreach (pend[k]) begin
            logic m1, m2;
            m1 = s1u && (pend[k].addr == s1a);
            m2 = s2u && (pend[k].addr == s2a);
            if (pend[k].age == D - 1) begin
                e.wbv = 1'b1;
                e.wba = pend[k].addr;
                if (FWD) begin
                    e.f1 = m1 && !e.mul;
                    e.f2 = m2 && !e.mul;
                end
            end
            if ((!FWD || pend[k].age < D - 1) && (m1 || m2)) hit = 1'b1;
        end
        e.haz   = iv && !e.mul && hit;
        e.stall = e.haz || e.mul;
        e.acc   = iv && !e.stall;
        exp_q.push_back(e);
        acc = e.acc;

        if (!e.mul) begin
            foreach (pend[k]) pend[k].age++;
            while (pend.size() > 0 && pend[pend.size()-1].age >= D) void'(pend.pop_back());
            if (e.acc && dwe) pend.push_front('{age: 0, addr: da});
        end
        if (mul_rem > 0) mul_rem--;
        else if (e.acc && im && MULC > 1) mul_rem = MULC - 1;
    endtask

    task automatic issue_until(input logic im,
                               input logic s1u, input logic [AW-1:0] s1a,
                               input logic s2u, input logic [AW-1:0] s2a,
                               input logic dwe, input logic [AW-1:0] da,
                               output int tries);
        logic acc;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            step(1'b1, im, s1u, s1a, s2u, s2a, dwe, da, acc);
            tries++;
        end
        check("accept_within_bound", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   tries;
        n_total = 0;
        n_pass  = 0;
        haz_cnt = 0;
        mul_cnt = 0;
        mul_rem = 0;

        rst             = 1'b1;
        bus.issue_valid = 1'b1;
        bus.is_mul      = 1'b1;
        bus.src1_used   = 1'b1;
        bus.src1_addr   = 3'd1;
        bus.src2_used   = 1'b1;
        bus.src2_addr   = 3'd2;
        bus.dst_wr_en   = 1'b1;
        bus.dst_addr    = 3'd3;
        #13;
        check("rst_issue_accept", 32'(bus.issue_accept), 32'd0);
        check("rst_stall",        32'(bus.stall),        32'd0);
        check("rst_wb_valid",     32'(bus.wb_valid),     32'd0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        rst = 1'b0;

        // Reset pulse while the multiplier is busy.
        idle(1);
        step(1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd6, acc);
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        check("busy_mul_stall", 32'(bus.mul_stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_mul_stall", 32'(bus.mul_stall), 32'd0);
        check("async_stall",     32'(bus.stall),     32'd0);
        check("async_wb_valid",  32'(bus.wb_valid),  32'd0);
        rst = 1'b0;
        pend.delete();
        mul_rem = 0;
        step(1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 3'd5, acc);
        idle(D + MULC);

        // Back-to-back RAW through r1.
        step(1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, acc);
        haz_cnt = 0;
        issue_until(1'b0, 1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd4, tries);
        @(negedge clk);
        #1;
        check("raw_haz_cycles", 32'(haz_cnt), FWD ? 32'd3 : 32'd4);
        check("raw_accept_try", 32'(tries),   FWD ? 32'd4 : 32'd5);
        idle(D + MULC);

        // MUL followed by an independent ADD.
        step(1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd6, acc);
        mul_cnt = 0;
        issue_until(1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd7, tries);
        @(negedge clk);
        #1;
        check("mul_stall_cycles", 32'(mul_cnt), 32'(MULC - 1));
        check("mul_add_try",      32'(tries),   32'(MULC));
        idle(D + MULC);

        // Unused source that matches a pending write must not stall.
        step(1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, acc);
        step(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 3'd5, 1'b1, 3'd4, acc);
        check("unused_src_accept", 32'(acc), 32'd1);
        // Same register on both sources, and dst equal to own source.
        step(1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd4, acc);
        step(1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd2, acc);
        idle(D + MULC);

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0,
                 1'($urandom), 3'($urandom),
                 1'($urandom), 3'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 3'($urandom),
                 acc);
        end
        idle(D + MULC);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
